// File: rtl/cdnsdru_usb4_message_bus_prio_tx_v4_pkg.sv
// Message-bus shared definitions: command encodings, priority-TX FSM states
// and a helper that builds the first (command) word of a bus transaction.
package cdnsdru_usb4_message_bus_pkg_v4;

  // Message-bus command nibbles (upper nibble of the first word)
  localparam logic [3:0] MB_CMD_NOP    = 4'h0;
  localparam logic [3:0] MB_CMD_WR_UC  = 4'h1;
  localparam logic [3:0] MB_CMD_WR_C   = 4'h2;
  localparam logic [3:0] MB_CMD_RD     = 4'h3;
  localparam logic [3:0] MB_CMD_RD_CPL = 4'h4;
  localparam logic [3:0] MB_CMD_WR_ACK = 4'h5;

  // Idle value of the bus
  localparam logic [7:0] MB_NOP_WORD = 8'h00;

  // Priority-TX FSM states
  typedef enum logic [2:0] {
    PTX_IDLE     = 3'd0,
    PTX_CMD      = 3'd1,
    PTX_ADDR     = 3'd2,
    PTX_DATA     = 3'd3,
    PTX_WAIT_ACK = 3'd4,
    PTX_DONE     = 3'd5
  } prio_tx_state_e;

  // First word of a transaction: command nibble followed by addr[11:8]
  function automatic logic [7:0] mb_cmd_word(input logic [3:0] cmd, input logic [3:0] addr_hi);
    return {cmd, addr_hi};
  endfunction

endpackage

// File: rtl/cdnsdru_usb4_message_bus_prio_tx_v4_arb.sv
// Fixed-priority one-hot arbiter: the lowest set request index wins.
module cdnsdru_usb4_message_bus_prio_arb_v4 #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found_s;

  // Walk from index 0 upward and grant the first active request only
  always_comb begin
    gnt_o   = {NUM_REQ{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && !found_s) begin
        gnt_o[i] = 1'b1;
        found_s  = 1'b1;
      end else begin
        gnt_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cdnsdru_usb4_message_bus_prio_tx_v4.sv
// Priority-write transmitter on the PHY-to-MAC message bus. Picks the
// highest-priority pending write, sends it as a 3-word write_committed,
// waits for write_ack with timeout/retry, and pulses sent/done per requester.
// All outputs are registered; their next values are derived from the FSM
// next state so that each bus word appears in the cycle of its state.
module cdnsdru_usb4_message_bus_prio_tx_v4
  import cdnsdru_usb4_message_bus_pkg_v4::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int RETRY_MAX   = 2
) (
  input  logic                    pipe_mac2phy_clk,
  input  logic                    pipe_mac2phy_rstn,
  input  logic                    mb_enable,
  input  logic                    cdb_reset,
  input  logic                    cdb_ctrl_reset,
  input  logic [NUM_REQ-1:0]      prio_tx_write,
  input  logic [NUM_REQ*12-1:0]   prio_addr,
  input  logic [NUM_REQ*8-1:0]    prio_data,
  input  logic                    tx_bus_busy,
  input  logic                    rx_write_ack,
  output logic [NUM_REQ-1:0]      prio_sent,
  output logic [NUM_REQ-1:0]      prio_tx_writes_done,
  output logic                    prio_tx_active,
  output logic [7:0]              p2m_message_bus,
  output logic                    ack_timeout_err
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

  logic ctrl_soft_reset_s;

  prio_tx_state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [11:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RW-1:0]      retry_q, retry_d;

  logic [7:0]         bus_q, bus_d;
  logic [NUM_REQ-1:0] sent_q, sent_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               active_q, active_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [11:0]        sel_addr_s;
  logic [7:0]         sel_data_s;

  assign ctrl_soft_reset_s = ~mb_enable | cdb_reset | cdb_ctrl_reset;

  cdnsdru_usb4_message_bus_prio_arb_v4 #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (prio_tx_write),
    .gnt_o (arb_gnt_s)
  );

  // One-hot mux of the winning requester's address and data
  always_comb begin
    sel_addr_s = {12{1'b0}};
    sel_data_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | (prio_addr[12*i +: 12] & {12{arb_gnt_s[i]}});
      sel_data_s = sel_data_s | (prio_data[8*i +: 8] & {8{arb_gnt_s[i]}});
    end
  end

  // FSM next state, grant/payload latch, ack timer and retry counter
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    timer_d = {TW{1'b0}};
    retry_d = retry_q;
    err_d   = 1'b0;
    case (state_q)
      PTX_IDLE: begin
        if ((|prio_tx_write) && !tx_bus_busy) begin
          gnt_d   = arb_gnt_s;
          addr_d  = sel_addr_s;
          data_d  = sel_data_s;
          state_d = PTX_CMD;
        end else begin
          state_d = PTX_IDLE;
        end
      end
      PTX_CMD:  state_d = PTX_ADDR;
      PTX_ADDR: state_d = PTX_DATA;
      PTX_DATA: state_d = PTX_WAIT_ACK;
      PTX_WAIT_ACK: begin
        // An ack arriving on the timeout cycle still counts as success
        if (rx_write_ack) begin
          state_d = PTX_DONE;
        end else if (timer_q == TIMER_LAST) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RW'(1);
            state_d = PTX_CMD;
          end else begin
            err_d   = 1'b1;
            state_d = PTX_DONE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PTX_DONE: begin
        retry_d = {RW{1'b0}};
        state_d = PTX_IDLE;
      end
      default: begin
        state_d = PTX_IDLE;
      end
    endcase
  end

  // Output values for the cycle the FSM is about to enter
  always_comb begin
    case (state_d)
      PTX_CMD:  bus_d = mb_cmd_word(MB_CMD_WR_C, addr_d[11:8]);
      PTX_ADDR: bus_d = addr_d[7:0];
      PTX_DATA: bus_d = data_d;
      default:  bus_d = MB_NOP_WORD;
    endcase
    // sent only on the first attempt (entry from IDLE), not on retries
    if ((state_d == PTX_CMD) && (state_q == PTX_IDLE)) begin
      sent_d = gnt_d;
    end else begin
      sent_d = {NUM_REQ{1'b0}};
    end
    if (state_d == PTX_DONE) begin
      done_d = gnt_d;
    end else begin
      done_d = {NUM_REQ{1'b0}};
    end
    active_d = (state_d != PTX_IDLE);
  end

  // State and output registers; soft reset behaves like the async reset
  always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
    if (!pipe_mac2phy_rstn) begin
      state_q  <= PTX_IDLE;
      gnt_q    <= {NUM_REQ{1'b0}};
      addr_q   <= 12'h000;
      data_q   <= 8'h00;
      timer_q  <= {TW{1'b0}};
      retry_q  <= {RW{1'b0}};
      bus_q    <= MB_NOP_WORD;
      sent_q   <= {NUM_REQ{1'b0}};
      done_q   <= {NUM_REQ{1'b0}};
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (ctrl_soft_reset_s) begin
      state_q  <= PTX_IDLE;
      gnt_q    <= {NUM_REQ{1'b0}};
      addr_q   <= 12'h000;
      data_q   <= 8'h00;
      timer_q  <= {TW{1'b0}};
      retry_q  <= {RW{1'b0}};
      bus_q    <= MB_NOP_WORD;
      sent_q   <= {NUM_REQ{1'b0}};
      done_q   <= {NUM_REQ{1'b0}};
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      bus_q    <= bus_d;
      sent_q   <= sent_d;
      done_q   <= done_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign p2m_message_bus     = bus_q;
  assign prio_sent           = sent_q;
  assign prio_tx_writes_done = done_q;
  assign prio_tx_active      = active_q;
  assign ack_timeout_err     = err_q;

endmodule

// File: tb/tb_cdnsdru_usb4_message_bus_prio_tx_v4.sv
// Directed self-checking bench for the message-bus priority transmitter.
// Expected bus words are queued when a request is driven and popped as the
// DUT serialises them. Inputs change and outputs are sampled on negedge.
module tb_cdnsdru_usb4_message_bus_prio_tx_v4;

  localparam int NUM_REQ     = 2;
  localparam int ACK_TIMEOUT = 64;
  localparam int RETRY_MAX   = 2;

  logic        clk            = 1'b0;
  logic        rstn           = 1'b0;
  logic        mb_enable      = 1'b1;
  logic        cdb_reset      = 1'b0;
  logic        cdb_ctrl_reset = 1'b0;
  logic [1:0]  req            = 2'b00;
  logic [23:0] addr           = 24'h000000;
  logic [15:0] data           = 16'h0000;
  logic        busy           = 1'b0;
  logic        ack            = 1'b0;

  logic [1:0]  sent;
  logic [1:0]  done;
  logic        active;
  logic [7:0]  bus;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  int gap;
  logic [1:0] s_seen, d_seen;
  logic       e_seen;
  logic [7:0] acc;

  logic [7:0] exp_q[$];

  cdnsdru_usb4_message_bus_prio_tx_v4 #(
    .NUM_REQ     (NUM_REQ),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .RETRY_MAX   (RETRY_MAX)
  ) dut (
    .pipe_mac2phy_clk    (clk),
    .pipe_mac2phy_rstn   (rstn),
    .mb_enable           (mb_enable),
    .cdb_reset           (cdb_reset),
    .cdb_ctrl_reset      (cdb_ctrl_reset),
    .prio_tx_write       (req),
    .prio_addr           (addr),
    .prio_data           (data),
    .tx_bus_busy         (busy),
    .rx_write_ack        (ack),
    .prio_sent           (sent),
    .prio_tx_writes_done (done),
    .prio_tx_active      (active),
    .p2m_message_bus     (bus),
    .ack_timeout_err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [11:0] a, input logic [7:0] d);
    exp_q.push_back({4'h2, a[11:8]});
    exp_q.push_back(a[7:0]);
    exp_q.push_back(d);
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    else return 8'hxx;
  endfunction

  task automatic set_req(input int idx, input logic [11:0] a, input logic [7:0] d);
    addr[12*idx +: 12] = a;
    data[8*idx +: 8]   = d;
    req[idx]           = 1'b1;
    push_frame(a, d);
  endtask

  // Called in the CMD cycle; ends in the DATA cycle
  task automatic check_frame(input string tag, input logic [1:0] exp_sent);
    chk({tag, "_cmd"}, 32'(bus), 32'(pop_exp()));
    chk({tag, "_sent"}, 32'(sent), 32'(exp_sent));
    chk({tag, "_active"}, 32'(active), 32'd1);
    tick();
    chk({tag, "_addr"}, 32'(bus), 32'(pop_exp()));
    chk({tag, "_sent_clr"}, 32'(sent), 32'd0);
    tick();
    chk({tag, "_data"}, 32'(bus), 32'(pop_exp()));
  endtask

  // Tick until the bus carries a word again, counting cycles and pulses
  task automatic wait_bus(input string tag, input int max, output int n,
                          output logic [1:0] s_o, output logic [1:0] d_o, output logic e_o);
    n = 0; s_o = 2'b00; d_o = 2'b00; e_o = 1'b0;
    tick(); n++;
    while (bus === 8'h00 && n < max) begin
      s_o |= sent; d_o |= done; e_o |= err;
      tick(); n++;
    end
    chk({tag, "_bus_seen"}, 32'(bus !== 8'h00), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_bus", 32'(bus), 32'h00);
    chk("rst_sent", 32'(sent), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    tick();

    // Stray ack in IDLE is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    chk("stray_ack_bus", 32'(bus), 32'h00);
    chk("stray_ack_active", 32'(active), 32'd0);

    // 1: single write, ack in the second WAIT_ACK cycle
    set_req(0, 12'h0A3, 8'h01);
    tick();
    check_frame("t1", 2'b01);
    tick();
    chk("t1_wait_bus", 32'(bus), 32'h00);
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_err", 32'(err), 32'd0);
    req[0] = 1'b0;
    tick();
    chk("t1_done_once", 32'(done), 32'd0);
    chk("t1_idle_active", 32'(active), 32'd0);

    // 2: collision, index 0 first, index 1 after one IDLE cycle
    set_req(0, 12'h155, 8'h5A);
    set_req(1, 12'hB7C, 8'hC3);
    tick();
    check_frame("t2a", 2'b01);
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    chk("t2a_done", 32'(done), 32'h1);
    req[0] = 1'b0;
    tick();
    chk("t2_gap_bus", 32'(bus), 32'h00);
    chk("t2_gap_done", 32'(done), 32'd0);
    tick();
    check_frame("t2b", 2'b10);
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    chk("t2b_done", 32'(done), 32'h2);
    req[1] = 1'b0;
    tick();

    // 3: busy blocks the grant; busy after the grant is ignored
    busy = 1'b1;
    set_req(1, 12'h3C4, 8'h99);
    acc = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc = acc | bus | {6'd0, sent};
    end
    chk("t3_busy_quiet", 32'(acc), 32'h00);
    busy = 1'b0;
    tick();
    busy = 1'b1;
    check_frame("t3", 2'b10);
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    chk("t3_done", 32'(done), 32'h2);
    req[1] = 1'b0; busy = 1'b0;
    tick();

    // 4: no ack at all -> 3 transmissions then abandon with error
    set_req(0, 12'h7E2, 8'h44);
    push_frame(12'h7E2, 8'h44);
    push_frame(12'h7E2, 8'h44);
    tick();
    check_frame("t4_tx0", 2'b01);
    wait_bus("t4_w0", 200, gap, s_seen, d_seen, e_seen);
    chk("t4_gap0", 32'(gap), 32'(ACK_TIMEOUT + 1));
    chk("t4_quiet0", 32'({s_seen, d_seen, e_seen}), 32'd0);
    check_frame("t4_tx1", 2'b00);
    wait_bus("t4_w1", 200, gap, s_seen, d_seen, e_seen);
    chk("t4_gap1", 32'(gap), 32'(ACK_TIMEOUT + 1));
    check_frame("t4_tx2", 2'b00);
    acc = 8'h00;
    for (int i = 0; i < ACK_TIMEOUT; i++) begin
      tick();
      acc = acc | {5'd0, done, err} | bus;
    end
    chk("t4_wait_quiet", 32'(acc), 32'h00);
    tick();
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_err", 32'(err), 32'd1);
    req[0] = 1'b0;
    tick();
    chk("t4_err_once", 32'(err), 32'd0);
    chk("t4_idle_active", 32'(active), 32'd0);

    // 5: first attempt times out, retry is acked
    set_req(1, 12'h0FF, 8'hE7);
    push_frame(12'h0FF, 8'hE7);
    tick();
    check_frame("t5_tx0", 2'b10);
    wait_bus("t5_w0", 200, gap, s_seen, d_seen, e_seen);
    chk("t5_gap", 32'(gap), 32'(ACK_TIMEOUT + 1));
    chk("t5_quiet", 32'({s_seen, d_seen, e_seen}), 32'd0);
    check_frame("t5_tx1", 2'b00);
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_done", 32'(done), 32'h2);
    chk("t5_no_err", 32'(err), 32'd0);
    req[1] = 1'b0;
    tick();

    // 6: controller soft reset during ADDR aborts; request re-served
    set_req(0, 12'h812, 8'h3D);
    tick();
    chk("t6_cmd", 32'(bus), 32'(pop_exp()));
    tick();
    chk("t6_addr", 32'(bus), 32'(pop_exp()));
    cdb_ctrl_reset = 1'b1;
    tick();
    chk("t6_rst_bus", 32'(bus), 32'h00);
    chk("t6_rst_outs", 32'({sent, done, active, err}), 32'd0);
    exp_q.delete();
    tick();
    chk("t6_rst_hold", 32'({bus, sent, done, active, err}), 32'd0);
    cdb_ctrl_reset = 1'b0;
    push_frame(12'h812, 8'h3D);
    tick();
    check_frame("t6_re", 2'b01);
    tick(); ack = 1'b1; tick(); ack = 1'b0;
    chk("t6_done", 32'(done), 32'h1);
    req[0] = 1'b0;
    tick();
    chk("t6_idle", 32'({bus, active}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
